// File: rtl/rf_op_sequencer.sv
// rf_op_sequencer
//
// Command-driven controller that sits directly in front of a register file
// (rf). It accepts one register-to-register command at a time, reads the two
// source operands from the rf, runs a small signed ALU with saturating
// add/subtract, writes the result back and returns it on a response channel.
//
// Sequence per command: IDLE -> READ -> EXEC -> WB -> RESP -> IDLE.
// The RD opcode skips WB and goes EXEC -> RESP.
//
// Ports:
//   clk, rst              clock, synchronous active-high reset
//   cmd_valid/cmd_ready   command handshake
//   cmd_op                3-bit opcode
//   cmd_rd                destination register
//   cmd_rs1/cmd_rs2       source registers
//   cmd_imm               signed immediate (LDI)
//   rsp_valid/rsp_ready   response handshake
//   rsp_data, rsp_ovf     signed result, saturation flag
//   busy                  controller is not idle
//   rf_chip_en            rf chip enable (active-high)
//   rf_write_en_n         rf write enable (active-low)
//   rf_data_in            rf write data
//   rf_read_addr_1/2      rf read addresses
//   rf_write_addr         rf write address
//   rf_data_out_1/2       rf combinational read data
module rf_op_sequencer #(
  parameter int BW    = 8,
  parameter int DEPTH = 256,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cmd_valid,
  output logic          cmd_ready,
  input  logic [2:0]    cmd_op,
  input  logic [AW-1:0] cmd_rd,
  input  logic [AW-1:0] cmd_rs1,
  input  logic [AW-1:0] cmd_rs2,
  input  logic [BW-1:0] cmd_imm,
  output logic          rsp_valid,
  input  logic          rsp_ready,
  output logic [BW-1:0] rsp_data,
  output logic          rsp_ovf,
  output logic          busy,
  output logic          rf_chip_en,
  output logic          rf_write_en_n,
  output logic [BW-1:0] rf_data_in,
  output logic [AW-1:0] rf_read_addr_1,
  output logic [AW-1:0] rf_read_addr_2,
  output logic [AW-1:0] rf_write_addr,
  input  logic [BW-1:0] rf_data_out_1,
  input  logic [BW-1:0] rf_data_out_2
);

  // FSM encoding
  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_READ = 3'd1;
  localparam logic [2:0] ST_EXEC = 3'd2;
  localparam logic [2:0] ST_WB   = 3'd3;
  localparam logic [2:0] ST_RESP = 3'd4;

  // Opcodes
  localparam logic [2:0] OP_LDI = 3'b000;
  localparam logic [2:0] OP_ADD = 3'b001;
  localparam logic [2:0] OP_SUB = 3'b010;
  localparam logic [2:0] OP_AND = 3'b011;
  localparam logic [2:0] OP_OR  = 3'b100;
  localparam logic [2:0] OP_XOR = 3'b101;
  localparam logic [2:0] OP_MOV = 3'b110;
  localparam logic [2:0] OP_RD  = 3'b111;

  logic [2:0]    state_reg,  state_next;
  logic [2:0]    op_reg,     op_next;
  logic [AW-1:0] rd_reg,     rd_next;
  logic [AW-1:0] rs1_reg,    rs1_next;
  logic [AW-1:0] rs2_reg,    rs2_next;
  logic [BW-1:0] imm_reg,    imm_next;
  logic [BW-1:0] a_reg,      a_next;
  logic [BW-1:0] b_reg,      b_next;
  logic [BW-1:0] result_reg, result_next;
  logic          ovf_reg,    ovf_next;

  // ---------------------------------------------------------------------------
  // ALU
  // ---------------------------------------------------------------------------

  // Clamp a BW+1-bit two's complement value into BW bits. The top two bits
  // disagree exactly when the value lies outside the BW-bit signed range;
  // the sign bit then tells which rail to clamp to.
  // Returns {saturated, clamped_value}.
  function automatic logic [BW:0] saturate(input logic [BW:0] wide);
    logic          clip;
    logic [BW-1:0] value;
    clip = wide[BW] ^ wide[BW-1];
    if (!clip)
      value = wide[BW-1:0];
    else if (wide[BW])
      value = {1'b1, {(BW-1){1'b0}}};
    else
      value = {1'b0, {(BW-1){1'b1}}};
    return {clip, value};
  endfunction

  logic [BW:0]   sum_wide;
  logic [BW:0]   diff_wide;
  logic [BW:0]   sum_sat;
  logic [BW:0]   diff_sat;
  logic [BW-1:0] and_bits;
  logic [BW-1:0] or_bits;
  logic [BW-1:0] xor_bits;
  logic [BW-1:0] alu_result;
  logic          alu_ovf;

  // Sign-extend both operands by one bit so the true sum/difference fits.
  assign sum_wide  = {a_reg[BW-1], a_reg} + {b_reg[BW-1], b_reg};
  assign diff_wide = {a_reg[BW-1], a_reg} - {b_reg[BW-1], b_reg};
  assign sum_sat   = saturate(sum_wide);
  assign diff_sat  = saturate(diff_wide);

  genvar gi;
  generate
    for (gi = 0; gi < BW; gi++) begin : g_logic_unit
      assign and_bits[gi] = a_reg[gi] & b_reg[gi];
      assign or_bits[gi]  = a_reg[gi] | b_reg[gi];
      assign xor_bits[gi] = a_reg[gi] ^ b_reg[gi];
    end
  endgenerate

  always_comb begin
    alu_result = '0;
    alu_ovf    = 1'b0;
    case (op_reg)
      OP_LDI: alu_result = imm_reg;
      OP_ADD: begin
        alu_result = sum_sat[BW-1:0];
        alu_ovf    = sum_sat[BW];
      end
      OP_SUB: begin
        alu_result = diff_sat[BW-1:0];
        alu_ovf    = diff_sat[BW];
      end
      OP_AND: alu_result = and_bits;
      OP_OR:  alu_result = or_bits;
      OP_XOR: alu_result = xor_bits;
      OP_MOV: alu_result = a_reg;
      OP_RD:  alu_result = a_reg;
      default: begin
        alu_result = '0;
        alu_ovf    = 1'b0;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_next  = state_reg;
    op_next     = op_reg;
    rd_next     = rd_reg;
    rs1_next    = rs1_reg;
    rs2_next    = rs2_reg;
    imm_next    = imm_reg;
    a_next      = a_reg;
    b_next      = b_reg;
    result_next = result_reg;
    ovf_next    = ovf_reg;

    case (state_reg)
      ST_IDLE: begin
        if (cmd_valid) begin
          op_next    = cmd_op;
          rd_next    = cmd_rd;
          rs1_next   = cmd_rs1;
          rs2_next   = cmd_rs2;
          imm_next   = cmd_imm;
          state_next = ST_READ;
        end
      end
      ST_READ: begin
        // Operands are captured before any write-back, so rd may alias rs1/rs2.
        a_next     = rf_data_out_1;
        b_next     = rf_data_out_2;
        state_next = ST_EXEC;
      end
      ST_EXEC: begin
        result_next = alu_result;
        ovf_next    = alu_ovf;
        state_next  = (op_reg == OP_RD) ? ST_RESP : ST_WB;
      end
      ST_WB: begin
        state_next = ST_RESP;
      end
      ST_RESP: begin
        // Result registers stay untouched here, so backpressure holds the data.
        if (rsp_ready)
          state_next = ST_IDLE;
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg  <= ST_IDLE;
      op_reg     <= '0;
      rd_reg     <= '0;
      rs1_reg    <= '0;
      rs2_reg    <= '0;
      imm_reg    <= '0;
      a_reg      <= '0;
      b_reg      <= '0;
      result_reg <= '0;
      ovf_reg    <= 1'b0;
    end else begin
      state_reg  <= state_next;
      op_reg     <= op_next;
      rd_reg     <= rd_next;
      rs1_reg    <= rs1_next;
      rs2_reg    <= rs2_next;
      imm_reg    <= imm_next;
      a_reg      <= a_next;
      b_reg      <= b_next;
      result_reg <= result_next;
      ovf_reg    <= ovf_next;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  logic in_read;
  logic in_wb;

  assign in_read = (state_reg == ST_READ);
  assign in_wb   = (state_reg == ST_WB);

  assign cmd_ready = (state_reg == ST_IDLE);
  assign busy      = (state_reg != ST_IDLE);
  assign rsp_valid = (state_reg == ST_RESP);
  assign rsp_data  = result_reg;
  assign rsp_ovf   = ovf_reg;

  // rst gates the rf strobes combinationally so a reset landing in WB cannot
  // complete the write on the same edge.
  assign rf_chip_en    = ~rst & (in_read | in_wb);
  assign rf_write_en_n = ~(~rst & in_wb);

  assign rf_read_addr_1 = in_read ? rs1_reg    : '0;
  assign rf_read_addr_2 = in_read ? rs2_reg    : '0;
  assign rf_write_addr  = in_wb   ? rd_reg     : '0;
  assign rf_data_in     = in_wb   ? result_reg : '0;

endmodule

// File: doc/rf_op_sequencer.md
Name: rf_op_sequencer

Overview:
- Command-driven controller placed directly upstream of the register file (rf). It drives rf's control, address and write-data pins, and consumes rf's two combinational read outputs.
- Accepts one register-to-register command at a time over a valid/ready handshake. Sequences read, execute, write-back and response.
- Executes a small signed ALU op set with saturation. Returns the result on a valid/ready response channel.

Parameters:
- BW, 8, data bitwidth; must equal rf BW.
- DEPTH, 256, number of rf rows; must equal rf DEPTH. Address width AW = $clog2(DEPTH), derived locally, not overridable.

Ports:
- clk  input  1  clock; all state updates on posedge.
- rst  input  1  synchronous reset, active-high.
- cmd_valid  input  1  command present.
- cmd_ready  output  1  sequencer can accept a command.
- cmd_op  input  3  opcode (see Behaviour).
- cmd_rd  input  AW  destination register.
- cmd_rs1  input  AW  source register 1.
- cmd_rs2  input  AW  source register 2.
- cmd_imm  input  BW  signed immediate (LDI only).
- rsp_valid  output  1  response present.
- rsp_ready  input  1  response consumer ready.
- rsp_data  output  BW  signed result.
- rsp_ovf  output  1  result was saturated.
- busy  output  1  state != IDLE.
- rf_chip_en  output  1  to rf chip_en (active-high).
- rf_write_en_n  output  1  to rf write_en_n (active-low).
- rf_data_in  output  BW  to rf data_in.
- rf_read_addr_1  output  AW  to rf read_addr_1.
- rf_read_addr_2  output  AW  to rf read_addr_2.
- rf_write_addr  output  AW  to rf write_addr.
- rf_data_out_1  input  BW  from rf data_out_1.
- rf_data_out_2  input  BW  from rf data_out_2.

Behaviour:
- Clock and reset:
  - One clock, clk. Reset is synchronous and active-high, port rst.
  - On a posedge with rst=1: state=IDLE; all internal registers, rsp_data and rsp_ovf become 0; rsp_valid=0.
  - rf's own async reset is driven separately and is not controlled by this block.
- Opcodes (a, b = operands latched from rs1, rs2):
  - 000 LDI: rd = imm
  - 001 ADD: rd = sat(a+b)
  - 010 SUB: rd = sat(a-b)
  - 011 AND: rd = a&b
  - 100 OR: rd = a|b
  - 101 XOR: rd = a^b
  - 110 MOV: rd = a
  - 111 RD: no write; response = a
- Arithmetic: ADD/SUB are computed at BW+1 bits signed, then clamped to [-2^(BW-1), 2^(BW-1)-1]. rsp_ovf=1 only when clamping occurred. All other ops give rsp_ovf=0.
- FSM: IDLE -> READ -> EXEC -> WB -> RESP -> IDLE. RD goes EXEC -> RESP and skips WB.
  - IDLE: cmd_ready=1. On cmd_valid&cmd_ready at an edge, latch op, rd, rs1, rs2, imm and go to READ. cmd_ready=0 in all other states.
  - READ: rf_chip_en=1, rf_write_en_n=1, read addresses = latched rs1/rs2. At the edge, latch rf_data_out_1/2 into a/b. All ops pass through READ, LDI included.
  - EXEC: register the result and ovf.
  - WB: rf_chip_en=1, rf_write_en_n=0, rf_write_addr=rd, rf_data_in=result. The rf write takes place at the edge ending WB.
  - RESP: rsp_valid=1, with rsp_data/rsp_ovf held stable. Leave to IDLE at the first edge with rsp_ready=1.
- Latency: command accepted at edge 0.
  - READ is cycle 1, WB is cycle 3.
  - rsp_valid rises in cycle 4, or cycle 3 for RD.
  - Minimum period between accepted commands is 5 cycles (4 for RD).
- Outputs outside READ/WB: rf_chip_en=0, rf_write_en_n=1, rf addresses 0, rf_data_in 0. With chip_en=0, rf read outputs are 0; the sequencer never samples them then.
- rst gating: rst=1 combinationally forces rf_chip_en=0 and rf_write_en_n=1. Reset asserted during WB therefore suppresses the write.
- Backpressure: while rsp_valid=1 and rsp_ready=0, hold all outputs. cmd_valid is ignored and nothing is accepted.
- Reset mid-operation from any state: return to IDLE, drop any pending response, perform no rf write.
- rd == rs1 or rd == rs2 is legal. Operands are read in READ, before the WB write.

Test Plan:
- Bench uses the real rf (BW=8, DEPTH=256) with its async reset pulsed once at the start.
- Reset: rst=1 for 2 cycles -> cmd_ready=1, rsp_valid=0, busy=0, rf_chip_en=0, rf_write_en_n=1, rsp_data=0.
- Load and saturating add: LDI r3=100, LDI r4=50, then ADD r5=r3+r4 -> WB drives write_addr=5 with data 127. Response 127 with rsp_ovf=1. A following RD r5 returns 127 with ovf=0.
- Subtract and logic: SUB r6=r4-r3 -> -50 (0xCE), ovf=0. XOR r7=r3^r4 -> 0x56. SUB with r3=-128, r4=50 -> -128, ovf=1.
- Timing: command accepted at edge 0 ->
  - rf_chip_en=1 with write_en_n=1 in cycle 1 only.
  - write_en_n=0 in cycle 3 only.
  - rsp_valid=1 in cycle 4.
  - For RD: no write_en_n=0 cycle, and rsp_valid=1 in cycle 3.
- Backpressure: rsp_ready=0 for 3 cycles with cmd_valid=1 held -> rsp_valid and rsp_data stable, cmd_ready=0. Next command accepted the cycle after the RESP handshake.
- Reset in WB: LDI r9=0x11, then LDI r9=0x22 with rst=1 during its WB cycle -> rf_write_en_n=1 that cycle, no response. RD r9 returns 0x11.
